// File: rtl/t1_resp_pkg.sv
// Shared definitions for the t1 1RW bank responder.
//   - t1_state_e   : init/run state of the shared clear FSM
//   - COLL/OOB/INIT_ACC : bit positions of the per-bank error-event vector
//   - calc_bitsrow : row-address width for a given row count
package t1_resp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } t1_state_e;

    localparam int unsigned EV_W     = 3;
    localparam int unsigned COLL     = 0;
    localparam int unsigned OOB      = 1;
    localparam int unsigned INIT_ACC = 2;

    function automatic int unsigned calc_bitsrow(input int unsigned nrow);
        return (nrow <= 1) ? 1 : $clog2(nrow);
    endfunction

endpackage

// File: rtl/t1_1rw_bank.sv
// One single-port 1RW SRAM bank behind the t1 port.
// Holds the row array, bit-write merge, SRAM_DELAY-deep read pipeline,
// collision / out-of-range detection and the sticky error flags.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   run             : shared FSM is in RUN (0 = clearing rows)
//   init_row        : row being cleared while run=0
//   rd, wr, addr    : strobes and row address for this bank
//   din, bw         : write data and bit-write enable (1 = write bit)
//   dout, vld       : read data (held between pulses) and valid pulse
//   coll_err, oob_err : sticky protocol error flags
//   ev              : this cycle's error events, indexed by COLL/OOB/INIT_ACC
// Optional (T1_RESP_ERRINJ_EN): inj_flip in, inj_done out.
module t1_1rw_bank
    import t1_resp_pkg::*;
#(
    parameter int unsigned NUMSROW    = 4096,
    parameter int unsigned BITSROW    = 12,
    parameter int unsigned PHYWDTH    = 128,
    parameter int unsigned SRAM_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [BITSROW-1:0] init_row,
    input  logic               rd,
    input  logic               wr,
    input  logic [BITSROW-1:0] addr,
    input  logic [PHYWDTH-1:0] din,
    input  logic [PHYWDTH-1:0] bw,
`ifdef T1_RESP_ERRINJ_EN
    input  logic               inj_flip,
    output logic               inj_done,
`endif
    output logic [PHYWDTH-1:0] dout,
    output logic               vld,
    output logic               coll_err,
    output logic               oob_err,
    output logic [EV_W-1:0]    ev
);

    localparam logic [BITSROW:0] NROW = (BITSROW + 1)'(NUMSROW);

    logic [PHYWDTH-1:0]    mem [NUMSROW];
    logic                  oob;
    logic                  coll;
    logic [PHYWDTH-1:0]    rd_data;
    logic [SRAM_DELAY-1:0] vld_p;
    logic [PHYWDTH-1:0]    dat_p [SRAM_DELAY];

    always_comb begin
        oob  = ({1'b0, addr} >= NROW);
        coll = rd & wr;
        ev   = '0;
        if (run) begin
            ev[COLL] = coll;
            ev[OOB]  = oob & (rd | wr);
        end else begin
            ev[INIT_ACC] = rd | wr;
        end
        // Illegal reads return zero; the array is never indexed out of range.
        rd_data = (coll || oob) ? '0 : mem[addr];
`ifdef T1_RESP_ERRINJ_EN
        rd_data[0] = rd_data[0] ^ inj_flip;
`endif
    end

    // Array has no reset; the INIT sweep clears it row by row.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[init_row] <= '0;
        end else if (wr && !oob) begin
            mem[addr] <= (mem[addr] & ~bw) | (din & bw);
        end
    end

    // Each stage's data only advances with a valid, so the last stage holds
    // the most recent read result between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
            for (int unsigned k = 0; k < SRAM_DELAY; k++) begin
                dat_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= rd & run;
            if (rd && run) begin
                dat_p[0] <= rd_data;
            end
            for (int unsigned k = 1; k < SRAM_DELAY; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) begin
                    dat_p[k] <= dat_p[k-1];
                end
            end
        end
    end

    assign vld  = vld_p[SRAM_DELAY-1];
    assign dout = dat_p[SRAM_DELAY-1];

`ifdef T1_RESP_ERRINJ_EN
    logic [SRAM_DELAY-1:0] inj_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_p <= '0;
        end else begin
            inj_p[0] <= rd & run & inj_flip;
            for (int unsigned k = 1; k < SRAM_DELAY; k++) begin
                inj_p[k] <= inj_p[k-1];
            end
        end
    end

    assign inj_done = inj_p[SRAM_DELAY-1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coll_err <= 1'b0;
            oob_err  <= 1'b0;
        end else begin
            if (ev[COLL]) coll_err <= 1'b1;
            if (ev[OOB])  oob_err  <= 1'b1;
        end
    end

endmodule

// File: rtl/t1_1rw_bank_responder.sv
// Target-side responder for the t1 physical-memory port: NUMVBNK 1RW banks
// with bit-write masks and SRAM_DELAY read latency. After reset every row is
// cleared (one row per cycle, all banks in parallel) before ready rises.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   ready      : high once the clear sweep has finished
//   t1_readA/t1_writeA/t1_addrA/t1_dinA/t1_bwA : per-bank request fields
//   t1_doutA/t1_vldA : per-bank read data and valid pulse
//   coll_err/oob_err : per-bank sticky protocol error flags
//   err_cnt    : saturating count of all illegal accesses
// Optional feature macro T1_RESP_ERRINJ_EN adds inj_flip (in) and inj_done
// (out): a read issued with inj_flip[b]=1 returns data with bit 0 inverted.
module t1_1rw_bank_responder
    import t1_resp_pkg::*;
#(
    parameter int unsigned NUMVBNK    = 1,
    parameter int unsigned NUMSROW    = 4096,
    parameter int unsigned BITSROW    = calc_bitsrow(NUMSROW),
    parameter int unsigned PHYWDTH    = 128,
    parameter int unsigned SRAM_DELAY = 1,
    parameter int unsigned ERRCNTW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready,
    input  logic [NUMVBNK-1:0]           t1_readA,
    input  logic [NUMVBNK-1:0]           t1_writeA,
    input  logic [NUMVBNK*BITSROW-1:0]   t1_addrA,
    input  logic [NUMVBNK*PHYWDTH-1:0]   t1_dinA,
    input  logic [NUMVBNK*PHYWDTH-1:0]   t1_bwA,
    output logic [NUMVBNK*PHYWDTH-1:0]   t1_doutA,
    output logic [NUMVBNK-1:0]           t1_vldA,
`ifdef T1_RESP_ERRINJ_EN
    input  logic [NUMVBNK-1:0]           inj_flip,
    output logic [NUMVBNK-1:0]           inj_done,
`endif
    output logic [NUMVBNK-1:0]           coll_err,
    output logic [NUMVBNK-1:0]           oob_err,
    output logic [ERRCNTW-1:0]           err_cnt
);

    localparam logic [BITSROW-1:0] LAST_ROW = BITSROW'(NUMSROW - 1);
    localparam logic [32:0]        CNT_MAX  = (33'd1 << ERRCNTW) - 33'd1;

    t1_state_e          state, state_nxt;
    logic [BITSROW-1:0] init_row, init_row_nxt;
    logic               run;
    logic [EV_W-1:0]    ev [NUMVBNK];
    logic [31:0]        ev_sum;
    logic [32:0]        cnt_tot;
    logic [ERRCNTW-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            init_row <= '0;
        end else begin
            state    <= state_nxt;
            init_row <= init_row_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_row_nxt = init_row;
        case (state)
            INIT: begin
                if (init_row == LAST_ROW) begin
                    state_nxt = RUN;
                end else begin
                    init_row_nxt = init_row + 1'b1;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign run   = (state == RUN);
    assign ready = run;

    for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
        t1_1rw_bank #(
            .NUMSROW    (NUMSROW),
            .BITSROW    (BITSROW),
            .PHYWDTH    (PHYWDTH),
            .SRAM_DELAY (SRAM_DELAY)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .run      (run),
            .init_row (init_row),
            .rd       (t1_readA[b]),
            .wr       (t1_writeA[b]),
            .addr     (t1_addrA[b*BITSROW +: BITSROW]),
            .din      (t1_dinA[b*PHYWDTH +: PHYWDTH]),
            .bw       (t1_bwA[b*PHYWDTH +: PHYWDTH]),
`ifdef T1_RESP_ERRINJ_EN
            .inj_flip (inj_flip[b]),
            .inj_done (inj_done[b]),
`endif
            .dout     (t1_doutA[b*PHYWDTH +: PHYWDTH]),
            .vld      (t1_vldA[b]),
            .coll_err (coll_err[b]),
            .oob_err  (oob_err[b]),
            .ev       (ev[b])
        );
    end

    // Sum in a 33-bit domain so the saturation compare cannot wrap.
    always_comb begin
        ev_sum = '0;
        for (int unsigned b = 0; b < NUMVBNK; b++) begin
            for (int unsigned e = 0; e < EV_W; e++) begin
                ev_sum = ev_sum + 32'(ev[b][e]);
            end
        end
        cnt_tot = {1'b0, 32'(err_cnt)} + {1'b0, ev_sum};
        cnt_nxt = (cnt_tot > CNT_MAX) ? ERRCNTW'(CNT_MAX) : ERRCNTW'(cnt_tot);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= cnt_nxt;
        end
    end

endmodule
